// File: rtl/wb_core_loader.sv
// Wishbone slave that loads core IMEM through a small write FIFO, holds the core in reset
// until RUN is set and the FIFO has drained, and provides a core->SoC mailbox with an IRQ.
`timescale 1ns/1ps
module wb_core_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          IMEM_AW    = 12,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               core_rst_no,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  input  logic               imem_rdy_i,
  input  logic               core_mbox_wr_i,
  input  logic [31:0]        core_mbox_data_i,
  output logic [2:0]         irq_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = IMEM_AW + 32;

  localparam logic [2:0] R_CTRL   = 3'd0;
  localparam logic [2:0] R_STATUS = 3'd1;
  localparam logic [2:0] R_IADDR  = 3'd2;
  localparam logic [2:0] R_IDATA  = 3'd3;
  localparam logic [2:0] R_MBOX   = 3'd4;

  logic                 run, irq_en;
  logic [IMEM_AW-1:0]   imem_addr;
  logic [FIFO_DEPTH-1:0][EW-1:0] fifo_mem;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [31:0]          mbox_data;
  logic                 mbox_valid, mbox_ovf;
  logic                 irq;

  logic                 hit, accept, stall, push, pop, is_data_wr;
  logic                 fifo_empty, fifo_full, mbox_rd, ovf_clr;
  logic [2:0]           reg_sel;
  logic [31:0]          rdata, be_mask, status;
  logic [IMEM_AW-1:0]   addr_masked;
  logic [EW-1:0]        head;
  logic                 unused_adr;

  assign unused_adr = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign reg_sel    = wbs_adr_i[4:2];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign is_data_wr = hit & wbs_we_i & (reg_sel == R_IDATA) & (wbs_sel_i == 4'hF);
  // A full FIFO withholds the ack; the write is retried every cycle until a pop has
  // been reflected in the registered count.
  assign stall      = is_data_wr & fifo_full;
  assign accept     = hit & ~wbs_ack_o & ~stall;
  assign push       = accept & is_data_wr;
  assign mbox_rd    = accept & ~wbs_we_i & (reg_sel == R_MBOX);
  assign ovf_clr    = accept & wbs_we_i & (reg_sel == R_STATUS) & wbs_dat_i[3];

  assign imem_we_o    = ~fifo_empty & ~run;
  assign pop          = imem_we_o & imem_rdy_i;
  assign head         = fifo_mem[rd_ptr];
  assign imem_addr_o  = imem_we_o ? head[EW-1:32] : '0;
  assign imem_wdata_o = imem_we_o ? head[31:0]    : '0;
  assign irq_o        = {2'b00, irq};

  assign be_mask     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign addr_masked = IMEM_AW'((32'(imem_addr) & ~be_mask) | (wbs_dat_i & be_mask));
  assign status      = {24'd0, 4'(count), mbox_ovf, mbox_valid, fifo_full, fifo_empty};

  always_comb begin
    rdata = '0;
    if (!wbs_we_i) begin
      case (reg_sel)
        R_CTRL:   rdata = {30'd0, irq_en, run};
        R_STATUS: rdata = status;
        R_IADDR:  rdata = 32'(imem_addr);
        R_MBOX:   rdata = mbox_data;
        default:  rdata = '0;
      endcase
    end
  end

  // Bus side: ack/data, control registers and address auto-increment
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      run       <= 1'b0;
      irq_en    <= 1'b0;
      imem_addr <= '0;
    end else begin
      wbs_ack_o <= accept;
      wbs_dat_o <= accept ? rdata : '0;
      if (accept && wbs_we_i) begin
        case (reg_sel)
          R_CTRL:  if (wbs_sel_i[0]) {irq_en, run} <= wbs_dat_i[1:0];
          R_IADDR: imem_addr <= addr_masked;
          default: ;
        endcase
      end
      if (push) imem_addr <= imem_addr + 1'b1;
    end
  end

  // Entries capture their address at push time so later IMEM_ADDR writes do not move them
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {imem_addr, wbs_dat_i};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Mailbox: a core write on the same edge as a bus read wins, so valid stays set
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mbox_data   <= '0;
      mbox_valid  <= 1'b0;
      mbox_ovf    <= 1'b0;
      irq         <= 1'b0;
      core_rst_no <= 1'b0;
    end else begin
      if (core_mbox_wr_i) begin
        mbox_data  <= core_mbox_data_i;
        mbox_valid <= 1'b1;
      end else if (mbox_rd) begin
        mbox_valid <= 1'b0;
      end
      if (ovf_clr) mbox_ovf <= 1'b0;
      if (core_mbox_wr_i && mbox_valid) mbox_ovf <= 1'b1;
      irq         <= mbox_valid & irq_en;
      core_rst_no <= run & fifo_empty;
    end
  end

endmodule

// File: tb/tb_wb_core_loader.sv
// Directed bench for wb_core_loader: IMEM load/wrap, stall on full FIFO, mailbox/IRQ, decode, reset.
`timescale 1ns/1ps
module tb_wb_core_loader;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0, wb_rst_ni = 1'b0;
  logic        wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
  logic [3:0]  wbs_sel_i = 0;
  logic [31:0] wbs_adr_i = 0, wbs_dat_i = 0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        core_rst_no, imem_we_o, imem_rdy_i = 0;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        core_mbox_wr_i = 0;
  logic [31:0] core_mbox_data_i = 0;
  logic [2:0]  irq_o;

  int checks = 0, errors = 0;
  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] rd;

  wb_core_loader #(.BASE_ADDR(BASE), .IMEM_AW(10), .FIFO_DEPTH(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .core_rst_no(core_rst_no),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .imem_rdy_i(imem_rdy_i), .core_mbox_wr_i(core_mbox_wr_i),
    .core_mbox_data_i(core_mbox_data_i), .irq_o(irq_o));

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i)
    if (imem_we_o && imem_rdy_i) begin
      wa_q.push_back(imem_addr_o);
      wd_q.push_back(imem_wdata_o);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc1();
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wb_xfer(input string tag, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel, output logic [31:0] data);
    bit acked = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    data = '0;
    for (int i = 0; i < 20 && !acked; i++) begin
      cyc1();
      if (wbs_ack_o) begin acked = 1; data = wbs_dat_o; end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    chk({"ack_", tag}, 32'(acked), 32'd1);
  endtask

  task automatic wb_wr(input string tag, input logic [31:0] off, input logic [31:0] dat,
                       input logic [3:0] sel = 4'hF);
    logic [31:0] dummy;
    wb_xfer(tag, BASE + off, 1'b1, dat, sel, dummy);
  endtask

  task automatic wb_rd(input string tag, input logic [31:0] off, output logic [31:0] data);
    wb_xfer(tag, BASE + off, 1'b0, 32'd0, 4'hF, data);
  endtask

  initial begin
    int n;
    bit seen;
    // reset state
    #12;
    chk("rst_core", 32'(core_rst_no), 0);
    chk("rst_ack", 32'(wbs_ack_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_we", 32'(imem_we_o), 0);
    cyc1(); wb_rst_ni = 1; cyc1();
    wb_rd("st0", 32'h04, rd); chk("status_reset", rd, 32'h01);

    // load with wrap, drain while RUN=0
    imem_rdy_i = 1;
    wb_wr("ia", 32'h08, 32'h3FF);
    wb_wr("d0", 32'h0C, 32'hA0A0_0001);
    wb_wr("d1", 32'h0C, 32'hA0A0_0002);
    wb_wr("d2", 32'h0C, 32'hA0A0_0003);
    repeat (3) cyc1();
    chk("load_cnt", wa_q.size(), 3);
    if (wa_q.size() == 3) begin
      chk("load_a0", 32'(wa_q[0]), 32'h3FF); chk("load_d0", wd_q[0], 32'hA0A0_0001);
      chk("load_a1", 32'(wa_q[1]), 32'h000); chk("load_d1", wd_q[1], 32'hA0A0_0002);
      chk("load_a2", 32'(wa_q[2]), 32'h001); chk("load_d2", wd_q[2], 32'hA0A0_0003);
    end
    wb_rd("ia_rd", 32'h08, rd); chk("iaddr_wrap", rd, 32'h002);
    chk("core_held", 32'(core_rst_no), 0);
    wb_wr("run", 32'h00, 32'h1);
    chk("core_rel_lat", 32'(core_rst_no), 0);
    cyc1();
    chk("core_rel", 32'(core_rst_no), 1);

    // push while running: no drain, core back in reset
    wa_q.delete(); wd_q.delete();
    wb_wr("d3", 32'h0C, 32'hD0D0_0004);
    chk("run_nowe", 32'(imem_we_o), 0);
    cyc1();
    chk("run_core_rst", 32'(core_rst_no), 0);
    wb_wr("stop", 32'h00, 32'h0);
    repeat (2) cyc1();
    chk("stop_drain_cnt", wa_q.size(), 1);
    if (wa_q.size() == 1) chk("stop_drain_a", 32'(wa_q[0]), 32'h002);
    chk("stop_core", 32'(core_rst_no), 0);

    // byte-masked IMEM_ADDR then stall on full FIFO
    wb_wr("ia_b0", 32'h08, 32'hFFFF_FF10, 4'h1);
    wb_rd("ia_b0_rd", 32'h08, rd); chk("iaddr_bytemask", rd, 32'h010);
    imem_rdy_i = 0; wa_q.delete(); wd_q.delete();
    for (int i = 0; i < 4; i++) wb_wr("fill", 32'h0C, 32'hE000_0000 + i);
    wb_rd("st_full", 32'h04, rd); chk("status_full", rd, 32'h42);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = BASE + 32'h0C;
    wbs_dat_i = 32'hE000_0004; wbs_sel_i = 4'hF;
    seen = 0;
    repeat (5) begin cyc1(); seen |= wbs_ack_o; end
    chk("stall_noack", 32'(seen), 0);
    imem_rdy_i = 1;
    n = 0; seen = 0;
    while (!seen && n < 20) begin cyc1(); n++; seen = wbs_ack_o; end
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    chk("stall_ack_lat", n, 2);
    repeat (6) cyc1();
    chk("stall_cnt", wa_q.size(), 5);
    if (wa_q.size() == 5) begin
      chk("stall_a4", 32'(wa_q[4]), 32'h014);
      chk("stall_d4", wd_q[4], 32'hE000_0004);
      chk("stall_a0", 32'(wa_q[0]), 32'h010);
    end

    // mailbox overflow and IRQ
    wb_wr("irqen", 32'h00, 32'h2);
    core_mbox_wr_i = 1; core_mbox_data_i = 32'h11; cyc1();
    core_mbox_data_i = 32'h22; cyc1();
    core_mbox_wr_i = 0; cyc1();
    chk("irq_set", 32'(irq_o), 32'h1);
    wb_rd("st_mb", 32'h04, rd); chk("status_mbox_ovf", rd, 32'h0D);
    wb_rd("mb", 32'h10, rd); chk("mbox_data", rd, 32'h22);
    repeat (2) cyc1();
    chk("irq_clr", 32'(irq_o), 32'h0);
    wb_rd("st_mb2", 32'h04, rd); chk("status_ovf_only", rd, 32'h09);
    wb_wr("ovfclr", 32'h04, 32'h8);
    wb_rd("st_mb3", 32'h04, rd); chk("status_ovf_clr", rd, 32'h01);

    // same-cycle core write and MBOX read
    core_mbox_wr_i = 1; core_mbox_data_i = 32'h33; cyc1(); core_mbox_wr_i = 0;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h10; wbs_sel_i = 4'hF;
    core_mbox_wr_i = 1; core_mbox_data_i = 32'h44;
    cyc1();
    core_mbox_wr_i = 0;
    chk("race_ack", 32'(wbs_ack_o), 1);
    chk("race_old", wbs_dat_o, 32'h33);
    wbs_cyc_i = 0; wbs_stb_i = 0; cyc1();
    wb_rd("st_race", 32'h04, rd); chk("race_status", rd, 32'h0D);
    wb_rd("mb2", 32'h10, rd); chk("race_new", rd, 32'h44);

    // partial IMEM_DATA write, other offset, decode miss
    wa_q.delete();
    wb_wr("part", 32'h0C, 32'hBAD0_0000, 4'h3);
    repeat (2) cyc1();
    chk("part_nopush", wa_q.size(), 0);
    wb_rd("idata_rd", 32'h0C, rd); chk("idata_read0", rd, 32'h0);
    wb_rd("other_rd", 32'h14, rd); chk("other_read0", rd, 32'h0);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h4000_0000;
    seen = 0;
    repeat (5) begin cyc1(); seen |= wbs_ack_o; end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    chk("miss_noack", 32'(seen), 0);

    // reset during a stalled write
    wb_wr("run2", 32'h00, 32'h1);
    for (int i = 0; i < 4; i++) wb_wr("fill2", 32'h0C, 32'hC000_0000 + i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = BASE + 32'h0C;
    wbs_dat_i = 32'hC000_0004; wbs_sel_i = 4'hF;
    repeat (2) cyc1();
    #2 wb_rst_ni = 0;
    #1;
    chk("arst_ack", 32'(wbs_ack_o), 0);
    chk("arst_core", 32'(core_rst_no), 0);
    chk("arst_we", 32'(imem_we_o), 0);
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    cyc1(); wb_rst_ni = 1; cyc1();
    wb_rd("st_arst", 32'h04, rd); chk("arst_status", rd, 32'h01);
    wb_rd("ctrl_arst", 32'h00, rd); chk("arst_ctrl", rd, 32'h0);
    wb_rd("ia_arst", 32'h08, rd); chk("arst_iaddr", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
